// File: rtl/alien_collision_pkg.sv
// rtl/alien_collision_pkg.sv - shared game geometry parameters and collision FSM state type
package alien_collision_pkg;

  localparam int ALIEN_ROWS = 2;
  localparam int ALIEN_COLS = 8;
  localparam int NUM_ALIENS = ALIEN_ROWS * ALIEN_COLS;
  localparam int ALIEN_W    = 8;
  localparam int ALIEN_H    = 6;
  localparam int COL_PITCH  = 16;
  localparam int ROW_PITCH  = 12;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  localparam logic [2:0] ERASE_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ERASE,
    ST_DONE
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alien_collision_if.sv
// rtl/alien_collision_if.sv - check request, alien status and erase-pixel stream bundle
interface alien_collision_if;

  logic        checkReq;
  logic [7:0]  bulletX;
  logic [6:0]  bulletY;
  logic [7:0]  baseX;
  logic [6:0]  baseY;
  logic        waveReset;
  logic        plotReady;

  logic        collidedWithAlien;
  logic        checkDone;
  logic [15:0] aliveMask;
  logic [7:0]  plotX;
  logic [6:0]  plotY;
  logic [2:0]  plotColour;
  logic        plotEn;
  logic [7:0]  score;
  logic        allDead;
  logic        busy;

  modport master (
    output checkReq, bulletX, bulletY, baseX, baseY, waveReset, plotReady,
    input  collidedWithAlien, checkDone, aliveMask, plotX, plotY, plotColour,
           plotEn, score, allDead, busy
  );

  modport slave (
    input  checkReq, bulletX, bulletY, baseX, baseY, waveReset, plotReady,
    output collidedWithAlien, checkDone, aliveMask, plotX, plotY, plotColour,
           plotEn, score, allDead, busy
  );

endinterface

// File: rtl/alien_collision_box_sweeper.sv
// rtl/alien_collision_box_sweeper.sv - raster sweep of a width x height box with ready backpressure
module box_sweeper (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_start,
  input  logic [7:0] i_origin_x,
  input  logic [6:0] i_origin_y,
  input  logic [3:0] i_width,
  input  logic [3:0] i_height,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic       o_done
);

  logic       r_active;
  logic [7:0] r_x;
  logic [7:0] r_ox;
  logic [6:0] r_y;
  logic [3:0] r_col;
  logic [3:0] r_row;
  logic [3:0] r_w;
  logic [3:0] r_h;

  logic w_accept;
  logic w_row_end;
  logic w_last;

  assign w_accept  = r_active && i_ready;
  assign w_row_end = (r_col == r_w - 4'd1);
  assign w_last    = w_row_end && (r_row == r_h - 4'd1);

  // Coordinates return to zero when idle so the stream reads as all-zero outside a sweep.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_active <= 1'b0;
      r_x      <= 8'd0;
      r_ox     <= 8'd0;
      r_y      <= 7'd0;
      r_col    <= 4'd0;
      r_row    <= 4'd0;
      r_w      <= 4'd0;
      r_h      <= 4'd0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_x      <= i_origin_x;
      r_ox     <= i_origin_x;
      r_y      <= i_origin_y;
      r_col    <= 4'd0;
      r_row    <= 4'd0;
      r_w      <= i_width;
      r_h      <= i_height;
    end else if (w_accept) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_x      <= 8'd0;
        r_y      <= 7'd0;
      end else if (w_row_end) begin
        r_col <= 4'd0;
        r_row <= r_row + 4'd1;
        r_x   <= r_ox;
        r_y   <= r_y + 7'd1;
      end else begin
        r_col <= r_col + 4'd1;
        r_x   <= r_x + 8'd1;
      end
    end
  end

  assign o_valid = r_active;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_done  = w_accept && w_last;

endmodule

// File: rtl/alien_collision.sv
// rtl/alien_collision.sv - scans the alien formation for a bullet hit and erases the hit alien
module alien_collision
  import alien_collision_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  alien_collision_if.slave bus
);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_bx;
  logic [6:0]  r_by;
  logic [7:0]  r_sx;
  logic [6:0]  r_sy;
  logic [15:0] r_alive;
  logic [7:0]  r_score;
  logic        r_collided;
  logic        r_check_done;
  logic        r_busy;

  logic [8:0]  w_ax;
  logic [7:0]  w_ay;
  logic        w_hit;
  logic        w_start;
  logic        w_sweep_done;
  logic        w_plot_en;
  logic [7:0]  w_plot_x;
  logic [6:0]  w_plot_y;

  // Box origin is kept one bit wider than the screen so formations near the edge never wrap.
  assign w_ax = {1'b0, r_sx} + 9'(COL_PITCH * int'(r_idx[2:0]));
  assign w_ay = {1'b0, r_sy} + (r_idx[3] ? 8'(ROW_PITCH) : 8'd0);

  assign w_hit = (r_state == ST_SCAN) && r_alive[r_idx]
              && ({1'b0, r_bx} >= w_ax) && ({1'b0, r_bx} <= w_ax + 9'(ALIEN_W - 1))
              && ({1'b0, r_by} >= w_ay) && ({1'b0, r_by} <= w_ay + 8'(ALIEN_H - 1))
              && (int'(r_bx) < SCREEN_W) && (int'(r_by) < SCREEN_H);

  assign w_start = w_hit;

  box_sweeper u_sweeper (
    .clk        (clk),
    .resetn     (reset),
    .i_start    (w_start),
    .i_origin_x (w_ax[7:0]),
    .i_origin_y (w_ay[6:0]),
    .i_width    (4'(ALIEN_W)),
    .i_height   (4'(ALIEN_H)),
    .i_ready    (bus.plotReady),
    .o_valid    (w_plot_en),
    .o_x        (w_plot_x),
    .o_y        (w_plot_y),
    .o_done     (w_sweep_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= 4'd0;
      r_bx         <= 8'd0;
      r_by         <= 7'd0;
      r_sx         <= 8'd0;
      r_sy         <= 7'd0;
      r_alive      <= 16'hFFFF;
      r_score      <= 8'd0;
      r_collided   <= 1'b0;
      r_check_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_collided   <= 1'b0;
      r_check_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.waveReset) begin
            r_alive <= 16'hFFFF;
          end else if (bus.checkReq) begin
            r_bx    <= bus.bulletX;
            r_by    <= bus.bulletY;
            r_sx    <= bus.baseX;
            r_sy    <= bus.baseY;
            r_idx   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            r_alive[r_idx] <= 1'b0;
            r_score        <= sat_inc8(r_score);
            r_collided     <= 1'b1;
            r_check_done   <= 1'b1;
            r_state        <= ST_ERASE;
          end else if (r_idx == 4'(NUM_ALIENS - 1)) begin
            r_check_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_DONE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        ST_ERASE: begin
          if (w_sweep_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.collidedWithAlien = r_collided;
  assign bus.checkDone         = r_check_done;
  assign bus.aliveMask         = r_alive;
  assign bus.plotX             = w_plot_x;
  assign bus.plotY             = w_plot_y;
  assign bus.plotColour        = w_plot_en ? ERASE_COLOUR : 3'b000;
  assign bus.plotEn            = w_plot_en;
  assign bus.score             = r_score;
  assign bus.allDead           = (r_alive == 16'h0000);
  assign bus.busy              = r_busy;

endmodule

// File: tb/tb_alien_collision.sv
// tb/tb_alien_collision.sv - self-checking bench for alien_collision
module tb_alien_collision;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alien_collision_if bus ();

  alien_collision dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] bx;
    logic [6:0] by;
    logic [7:0] sx;
    logic [6:0] sy;
    int         stall_at;
    bit         inject;
    bit         hit;
    int         idx;
    int         ax;
    int         ay;
  } vec_t;

  typedef struct {
    bit hit;
    int idx;
    int ax;
    int ay;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[7];
  logic [15:0] m_alive;
  int          m_score;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int bx, input int by, input int sx, input int sy,
                              input int stall_at, input bit inject, input bit hit,
                              input int idx, input int ax, input int ay);
    vec_t v;
    v.bx = 8'(bx); v.by = 7'(by); v.sx = 8'(sx); v.sy = 7'(sy);
    v.stall_at = stall_at; v.inject = inject; v.hit = hit;
    v.idx = idx; v.ax = ax; v.ay = ay;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    m_alive = 16'hFFFF;
    m_score = 0;
  endtask

  task automatic run_check(input vec_t v);
    exp_t e, got;
    int cyc, done_cyc, done_cnt, n_acc, pix_err, busy_err, pulse_err, stall_cnt, ex, ey;
    bit coll;
    e.hit = v.hit; e.idx = v.idx; e.ax = v.ax; e.ay = v.ay;
    sb_q.push_back(e);
    if (v.hit) begin
      m_alive[v.idx] = 1'b0;
      if (m_score < 255) m_score++;
    end
    bus.bulletX = v.bx; bus.bulletY = v.by; bus.baseX = v.sx; bus.baseY = v.sy;
    bus.waveReset = 1'b0; bus.plotReady = 1'b1; bus.checkReq = 1'b1;
    @(posedge clk); #1;
    bus.checkReq = 1'b0;
    cyc = 1; done_cyc = -1; done_cnt = 0; n_acc = 0; pix_err = 0;
    busy_err = 0; pulse_err = 0; stall_cnt = 0; coll = 1'b0;
    while (cyc < 300) begin
      if (v.inject && cyc == 5) begin
        bus.checkReq = 1'b1; bus.bulletX = 8'd22; bus.bulletY = 7'd12;
      end else begin
        bus.checkReq = 1'b0;
      end
      if (bus.checkDone) begin
        done_cnt++; done_cyc = cyc; coll = bus.collidedWithAlien;
      end else if (bus.collidedWithAlien) begin
        pulse_err++;
      end
      if (done_cyc < 0 && !bus.busy) busy_err++;
      bus.plotReady = 1'b1;
      if (bus.plotEn) begin
        ex = e.ax + n_acc % 8;
        ey = e.ay + n_acc / 8;
        if (!bus.busy) busy_err++;
        if (int'(bus.plotX) != ex || int'(bus.plotY) != ey || bus.plotColour != 3'b000) pix_err++;
        if (n_acc == v.stall_at && stall_cnt < 5) begin
          bus.plotReady = 1'b0;
          stall_cnt++;
        end else begin
          n_acc++;
        end
      end
      if (done_cyc > 0 && !bus.busy && !bus.plotEn) break;
      @(posedge clk); #1;
      cyc++;
    end
    bus.checkReq = 1'b0;
    chk("finish_in_budget", int'(cyc < 300), 1);
    got = sb_q.pop_front();
    chk("done_latency", done_cyc, got.hit ? got.idx + 2 : 17);
    chk("done_pulses", done_cnt, 1);
    chk("collided", int'(coll), int'(got.hit));
    chk("pixels_accepted", n_acc, got.hit ? 48 : 0);
    chk("pixel_sequence", pix_err, 0);
    chk("busy_held", busy_err, 0);
    chk("stray_collide", pulse_err, 0);
    if (v.stall_at >= 0) chk("stall_cycles", stall_cnt, 5);
    @(posedge clk); #1;
    chk("alive_mask", int'(bus.aliveMask), int'(m_alive));
    chk("score", int'(bus.score), m_score);
    chk("all_dead", int'(bus.allDead), int'(m_alive == 16'h0000));
    chk("busy_idle", int'(bus.busy), 0);
    chk("plot_idle", int'(bus.plotEn), 0);
  endtask

  initial begin
    vec_t v;
    int   n, k, cnt;
    bus.checkReq = 1'b0; bus.bulletX = 8'd0; bus.bulletY = 7'd0;
    bus.baseX = 8'd0; bus.baseY = 7'd0; bus.waveReset = 1'b0; bus.plotReady = 1'b1;
    do_reset();
    chk("rst_mask", int'(bus.aliveMask), 16'hFFFF);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_plot", int'(bus.plotEn) + int'(bus.plotX) + int'(bus.plotY) + int'(bus.plotColour), 0);
    chk("rst_pulses", int'(bus.checkDone) + int'(bus.collidedWithAlien), 0);
    chk("rst_alldead", int'(bus.allDead), 0);

    vecs[0] = mk(55, 24, 20, 10, -1, 1'b1, 1'b1, 10, 52, 22);
    vecs[1] = mk(30, 12, 20, 10, -1, 1'b0, 1'b0, 0, 0, 0);
    vecs[2] = mk(55, 24, 20, 10, -1, 1'b0, 1'b0, 0, 0, 0);
    vecs[3] = mk(160, 12, 155, 10, -1, 1'b0, 1'b0, 0, 0, 0);
    vecs[4] = mk(22, 12, 20, 10, 20, 1'b0, 1'b1, 0, 20, 10);
    vecs[5] = mk(139, 27, 20, 10, -1, 1'b0, 1'b1, 15, 132, 22);
    vecs[6] = mk(159, 24, 155, 10, -1, 1'b0, 1'b1, 8, 155, 22);
    foreach (vecs[i]) run_check(vecs[i]);

    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin
        v = mk(20 + 16 * c + 3, 10 + 12 * r + 2, 20, 10, -1, 1'b0, 1'b1,
               r * 8 + c, 20 + 16 * c, 10 + 12 * r);
        run_check(v);
      end
    end
    chk("wave_alldead", int'(bus.allDead), 1);
    chk("wave_score", int'(bus.score), 16);
    bus.waveReset = 1'b1;
    @(posedge clk); #1;
    bus.waveReset = 1'b0;
    m_alive = 16'hFFFF;
    chk("wave_restore", int'(bus.aliveMask), 16'hFFFF);
    chk("wave_score_kept", int'(bus.score), 16);

    bus.bulletX = 8'd55; bus.bulletY = 7'd24; bus.baseX = 8'd20; bus.baseY = 7'd10;
    bus.waveReset = 1'b1; bus.checkReq = 1'b1;
    @(posedge clk); #1;
    bus.waveReset = 1'b0; bus.checkReq = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.checkDone || bus.busy) cnt++;
      @(posedge clk); #1;
    end
    chk("wave_wins_drop", cnt, 0);
    chk("wave_wins_mask", int'(bus.aliveMask), 16'hFFFF);

    bus.plotReady = 1'b1; bus.checkReq = 1'b1;
    @(posedge clk); #1;
    bus.checkReq = 1'b0;
    n = 0; k = 0;
    while (k < 100 && !(bus.plotEn && n == 10)) begin
      if (bus.plotEn) n++;
      @(posedge clk); #1;
      k++;
    end
    chk("mid_erase_reached", int'(k < 100), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_alive = 16'hFFFF; m_score = 0;
    chk("mid_rst_plot", int'(bus.plotEn) + int'(bus.plotX) + int'(bus.plotY), 0);
    chk("mid_rst_mask", int'(bus.aliveMask), 16'hFFFF);
    chk("mid_rst_score", int'(bus.score), 0);
    chk("mid_rst_busy", int'(bus.busy) + int'(bus.checkDone) + int'(bus.collidedWithAlien), 0);
    run_check(mk(30, 12, 20, 10, -1, 1'b0, 1'b0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
